alu_muldiv_unit: RTL and testbench

//   Sequential issue stage wrapped around the combinational Multiplication array: registers operands, converts signed operands to

---
 rtl/alu_muldiv_unit_if.sv | 31 +++
 rtl/alu_muldiv_unit.sv | 213 +++++++++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_unit_if.sv
// Handshake/bus bundle for alu_muldiv_unit.
//   Upstream request : in_valid, in_ready, op, a, b
//   Downstream result: out_valid, out_ready, result, overflow, div_by_zero
//   Status           : busy
// The master modport is the side that issues requests and consumes results
// (decode/writeback); the slave modport is the multiply/divide unit.
interface alu_muldiv_unit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, div_by_zero, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, overflow, div_by_zero, busy
  );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Sequential multiply/divide issue stage.
//   Captures a request (op, a, b), converts signed operands to magnitudes,
//   runs the combinational Multiplication array (MUL) or an internal
//   restoring divider (DIV/REM, one quotient bit per cycle), re-applies the
//   sign, computes overflow/divide-by-zero and holds the result until the
//   downstream stage accepts it.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : in_valid/in_ready/op/a/b request handshake,
//                 out_valid/out_ready/result/overflow/div_by_zero result
//                 handshake, busy status
// op: 00 MUL signed, 01 MUL unsigned, 10 DIV signed, 11 REM signed.
// Optional feature macro: MULDIV_ZERO_SKIP_EN (zero-operand short path).

// Combinational multiplier array: low l bits of the product plus a flag
// when the full product does not fit in l bits.
module Multiplication #(
  parameter int l = 16
) (
  input  logic [l-1:0] A,
  input  logic [l-1:0] B,
  output logic [l-1:0] R1,
  output logic         Overflow
);
  logic [2*l-1:0] full;

  assign full     = {{l{1'b0}}, A} * {{l{1'b0}}, B};
  assign R1       = full[l-1:0];
  assign Overflow = |full[2*l-1:l];
endmodule

module alu_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_muldiv_unit_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_EXEC,
    S_FIX,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q;
  logic             sign_q;
  logic [WIDTH-1:0] prod_q;
  logic             arr_ovf_q;
  logic [WIDTH-1:0] quo_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q;
  logic [WIDTH-1:0] result_q;
  logic             ovf_q, dbz_q;

  // Operand decode on the captured request
  logic             is_div, is_signed, b_zero, zero_skip;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_res;

  assign is_div    = op_q[1];
  assign is_signed = (op_q != 2'b01);
  assign b_zero    = (b_q == '0);
  assign mag_a     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
  assign sign_res  = (op_q == 2'b11) ? a_q[WIDTH-1]
                   : (is_signed ? (a_q[WIDTH-1] ^ b_q[WIDTH-1]) : 1'b0);

`ifdef MULDIV_ZERO_SKIP_EN
  assign zero_skip = is_div ? ((a_q == '0) && !b_zero) : ((a_q == '0) || b_zero);
`else
  assign zero_skip = 1'b0;
`endif

  // Multiplier array on the magnitudes
  logic [WIDTH-1:0] mul_r1;
  logic             mul_ovf;

  Multiplication #(.l(WIDTH)) u_mul (
    .A        (mag_a_q),
    .B        (mag_b_q),
    .R1       (mul_r1),
    .Overflow (mul_ovf)
  );

  // One restoring-division step: shift next dividend bit into the partial
  // remainder and subtract the divisor if it fits.
  logic [WIDTH:0] rem_sh, trial;
  logic           fits;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, mag_b_q};
  assign fits   = !trial[WIDTH];

  // Result fix-up: sign re-application and flags
  logic [WIDTH-1:0] raw, fix_result;
  logic             fix_ovf, fix_dbz;

  always_comb begin
    raw        = is_div ? (op_q[0] ? rem_q : quo_q) : prod_q;
    fix_result = sign_q ? -raw : raw;
    fix_ovf    = 1'b0;
    fix_dbz    = 1'b0;
    if (zero_q) begin
      fix_result = '0;
    end else if (is_div && b_zero) begin
      fix_result = op_q[0] ? a_q : '1;
      fix_dbz    = 1'b1;
    end else begin
      case (op_q)
        2'b00:   fix_ovf = arr_ovf_q | (!sign_q && (prod_q >= HALF))
                                     | (sign_q && (prod_q > HALF));
        2'b01:   fix_ovf = arr_ovf_q;
        2'b10:   fix_ovf = (a_q == HALF) && (b_q == '1);
        default: fix_ovf = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Zero-skip requests are routed through FIX (with zero_q forcing the
  // value) so they land on the same 2-cycle latency as divide-by-zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_PREP;
      S_PREP: begin
        if (zero_skip || (is_div && b_zero)) state_d = S_FIX;
        else                                 state_d = S_EXEC;
      end
      S_EXEC: if (!is_div || (cnt_q == '0)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      sign_q    <= 1'b0;
      prod_q    <= '0;
      arr_ovf_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            ovf_q <= 1'b0;
            dbz_q <= 1'b0;
          end
        end
        S_PREP: begin
          mag_a_q <= mag_a;
          mag_b_q <= mag_b;
          sign_q  <= sign_res;
          quo_q   <= mag_a;
          rem_q   <= '0;
          cnt_q   <= CNT_W'(WIDTH - 1);
          zero_q  <= zero_skip;
        end
        S_EXEC: begin
          if (!is_div) begin
            prod_q    <= mul_r1;
            arr_ovf_q <= mul_ovf;
          end else begin
            rem_q <= fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          result_q <= fix_result;
          ovf_q    <= fix_ovf;
          dbz_q    <= fix_dbz;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.result      = result_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
module tb_alu_muldiv_unit;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_muldiv_unit_if #(.WIDTH(W)) bus ();

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        dbz;
    int          lat;
  } vec_t;

  // Issue one request and wait (bounded) for out_valid; lat=0 on timeout.
  task automatic run_op(input logic [1:0] o, input logic [15:0] av, input logic [15:0] bv,
                        output int lat, output bit accepted);
    int g = 0;
    lat = 0;
    accepted = 1'b0;
    @(negedge clk);
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) return;
    accepted = 1'b1;
    bus.op = o;
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~av;
    bus.b = 16'h5A5A;
    bus.op = ~o;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== 16'h0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b res=%h ovf=%b dbz=%b expected 1 0 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.overflow, bus.div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    vec_t v[8];
    int lat;
    bit acc;
    v = '{
      '{2'b00, 16'hFFFD, 16'h0007, 16'hFFEB, 1'b0, 1'b0, 3},
      '{2'b00, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 3},
      '{2'b01, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 3},
      '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 3},
      '{2'b00, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b0, 3},
      '{2'b00, 16'h4000, 16'h0002, 16'h8000, 1'b1, 1'b0, 3},
      '{2'b01, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 3},
      '{2'b01, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b0, 3}
    };
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, acc);
      vectors++;
      if (!acc || lat !== v[i].lat) begin
        miscompares++;
        $display("FAIL mul[%0d] latency: got %0d (accepted=%0d) expected %0d", i, lat, acc, v[i].lat);
      end
      vectors++;
      if (bus.result !== v[i].res || bus.overflow !== v[i].ovf || bus.div_by_zero !== v[i].dbz) begin
        miscompares++;
        $display("FAIL mul[%0d] result: got %h ovf=%b dbz=%b expected %h ovf=%b dbz=%b",
                 i, bus.result, bus.overflow, bus.div_by_zero, v[i].res, v[i].ovf, v[i].dbz);
      end
      drain();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mul[%0d] drain: got out_valid=%b expected 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[10];
    int lat;
    bit acc;
    v = '{
      '{2'b10, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0, 18},
      '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 18},
      '{2'b10, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 18},
      '{2'b11, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18},
      '{2'b10, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0, 18},
      '{2'b11, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0, 18},
      '{2'b10, 16'h0007, 16'hFFFE, 16'hFFFD, 1'b0, 1'b0, 18},
      '{2'b11, 16'h0007, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 18},
      '{2'b10, 16'h0005, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 2},
      '{2'b11, 16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b1, 2}
    };
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, acc);
      vectors++;
      if (!acc || lat !== v[i].lat) begin
        miscompares++;
        $display("FAIL div[%0d] latency: got %0d (accepted=%0d) expected %0d", i, lat, acc, v[i].lat);
      end
      vectors++;
      if (bus.result !== v[i].res || bus.overflow !== v[i].ovf || bus.div_by_zero !== v[i].dbz) begin
        miscompares++;
        $display("FAIL div[%0d] result: got %h ovf=%b dbz=%b expected %h ovf=%b dbz=%b",
                 i, bus.result, bus.overflow, bus.div_by_zero, v[i].res, v[i].ovf, v[i].dbz);
      end
      drain();
    end
  endtask

  task automatic test_zero_operand();
    int lat;
    bit acc;
    int exp_lat;
`ifdef MULDIV_ZERO_SKIP_EN
    exp_lat = 2;
`else
    exp_lat = 3;
`endif
    run_op(2'b00, 16'h0000, 16'h1234, lat, acc);
    vectors++;
    if (!acc || lat !== exp_lat) begin
      miscompares++;
      $display("FAIL zero_mul latency: got %0d expected %0d", lat, exp_lat);
    end
    vectors++;
    if (bus.result !== 16'h0000 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_mul result: got %h ovf=%b dbz=%b expected 0000 0 0",
               bus.result, bus.overflow, bus.div_by_zero);
    end
    drain();
  endtask

  task automatic test_hold();
    int lat;
    bit acc;
    run_op(2'b00, 16'hFFFD, 16'h0007, lat, acc);
    vectors++;
    if (!acc || lat !== 3) begin
      miscompares++;
      $display("FAIL hold latency: got %0d expected 3", lat);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1 ||
          bus.result !== 16'hFFEB || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: got vld=%b rdy=%b busy=%b res=%h ovf=%b dbz=%b expected 1 0 1 ffeb 0 0",
                 c, bus.out_valid, bus.in_ready, bus.busy, bus.result, bus.overflow, bus.div_by_zero);
      end
    end
    drain();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: got vld=%b rdy=%b expected 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    bit acc;
    run_op(2'b00, 16'h0003, 16'h0005, lat, acc);
    vectors++;
    if (!acc || lat !== 3 || bus.result !== 16'h000F) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d res=%h expected lat=3 res=000f", lat, bus.result);
    end
    drain();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got in_ready=%b expected 1", bus.in_ready);
    end
    run_op(2'b01, 16'h0002, 16'h0003, lat, acc);
    vectors++;
    if (!acc || lat !== 3 || bus.result !== 16'h0006) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d res=%h expected lat=3 res=0006", lat, bus.result);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    bus.op = 2'b10;
    bus.a = 16'h1234;
    bus.b = 16'h0003;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy: got busy=%b expected 1", bus.busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.result !== 16'h0 || bus.overflow !== 1'b0 || bus.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got rdy=%b vld=%b busy=%b res=%h ovf=%b dbz=%b expected 1 0 0 0000 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.result, bus.overflow, bus.div_by_zero);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_no_result: got activity=%b expected 0", seen);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_mul();
    test_div();
    test_zero_operand();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
